// File: rtl/demultiplexer_4x8_capture.sv
// Routes a keypad digit, one per rising edge of in_valid, into one of two
// shift-in digit buffers (L0 = entered code, L1 = new code candidate).

module demultiplexer_4x8_capture_lane #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  clr,
  input  logic [3:0]            d,
  output logic [4*DIGITS-1:0]   data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  rej
);
  logic [4*DIGITS-1:0] d_ext;

  assign d_ext = (4*DIGITS)'(d);
  // Clear suppresses the overflow report: a dropped digit on a clear is expected.
  assign rej   = wr & full & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      data  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (wr && !full) begin
      data  <= (data << 4) | d_ext;
      count <= count + 1'b1;
      full  <= (count == CNT_W'(DIGITS - 1));
    end
  end
endmodule

module demultiplexer_4x8_capture #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_msb,
  input  logic                in_b,
  input  logic                in_c,
  input  logic                in_lsb,
  input  logic                in_valid,
  input  logic                S,
  input  logic                clr_L0,
  input  logic                clr_L1,
  output logic                in_ready,
  output logic [4*DIGITS-1:0] out_L0,
  output logic [4*DIGITS-1:0] out_L1,
  output logic [CNT_W-1:0]    count_L0,
  output logic [CNT_W-1:0]    count_L1,
  output logic                full_L0,
  output logic                full_L1,
  output logic                ovf
);
  localparam int NUM_LANES = 2;

  logic                                  valid_q;
  logic                                  acc;
  logic [3:0]                            digit;
  logic [NUM_LANES-1:0]                  wr;
  logic [NUM_LANES-1:0]                  clr;
  logic [NUM_LANES-1:0]                  full;
  logic [NUM_LANES-1:0]                  rej;
  logic [NUM_LANES-1:0][4*DIGITS-1:0]    data;
  logic [NUM_LANES-1:0][CNT_W-1:0]       count;

  // A held key must deliver exactly one digit: act only on the rising edge.
  assign acc   = in_valid & ~valid_q;
  assign digit = {in_msb, in_b, in_c, in_lsb};
  assign wr    = {acc & S, acc & ~S};
  assign clr   = {clr_L1, clr_L0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid_q <= in_valid;
      ovf     <= |rej;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demultiplexer_4x8_capture_lane #(.DIGITS(DIGITS), .CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[i]),
      .clr   (clr[i]),
      .d     (digit),
      .data  (data[i]),
      .count (count[i]),
      .full  (full[i]),
      .rej   (rej[i])
    );
  end

  assign out_L0   = data[0];
  assign out_L1   = data[1];
  assign count_L0 = count[0];
  assign count_L1 = count[1];
  assign full_L0  = full[0];
  assign full_L1  = full[1];
  assign in_ready = S ? ~full[1] : ~full[0];
endmodule

// File: tb/tb_demultiplexer_4x8_capture.sv
// Directed bench for the two-buffer keypad digit demultiplexer.

module tb_demultiplexer_4x8_capture;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, S, clr_L0, clr_L1;
  logic [3:0]  dig;
  logic        in_ready, full_L0, full_L1, ovf;
  logic [15:0] out_L0, out_L1;
  logic [2:0]  count_L0, count_L1;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  demultiplexer_4x8_capture #(.DIGITS(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_msb   (dig[3]),
    .in_b     (dig[2]),
    .in_c     (dig[1]),
    .in_lsb   (dig[0]),
    .in_valid (in_valid),
    .S        (S),
    .clr_L0   (clr_L0),
    .clr_L1   (clr_L1),
    .in_ready (in_ready),
    .out_L0   (out_L0),
    .out_L1   (out_L1),
    .count_L0 (count_L0),
    .count_L1 (count_L1),
    .full_L0  (full_L0),
    .full_L1  (full_L1),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One keypress: 3-cycle in_valid pulse followed by one low cycle.
  task automatic press(input logic s, input logic [3:0] d);
    @(negedge clk);
    S = s; dig = d; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_both();
    @(negedge clk);
    clr_L0 = 1'b1; clr_L1 = 1'b1;
    @(negedge clk);
    clr_L0 = 1'b0; clr_L1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; S = 1'b0; clr_L0 = 1'b0; clr_L1 = 1'b0; dig = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_out_L0", out_L0, 0);
    check("rst_out_L1", out_L1, 0);
    check("rst_count_L0", count_L0, 0);
    check("rst_full_L0", full_L0, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // 1: fill L0
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3);
    check("t1_not_full_yet", full_L0, 0);
    press(0, 4'h4);
    check("t1_out_L0", out_L0, 16'h1234);
    check("t1_count_L0", count_L0, 4);
    check("t1_full_L0", full_L0, 1);
    check("t1_out_L1", out_L1, 0);
    check("t1_in_ready", in_ready, 0);

    // 2: held key delivers one digit
    @(negedge clk);
    S = 1'b1; dig = 4'h7; in_valid = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_count_L1", count_L1, 1);
    check("t2_out_L1", out_L1, 16'h0007);
    in_valid = 1'b0;
    @(negedge clk);

    // 3: overflow pulse on full L0, then L1 accepts
    S = 1'b0; dig = 4'h9; in_valid = 1'b1;
    @(negedge clk);
    check("t3_ovf_pulse", ovf, 1);
    @(negedge clk);
    check("t3_ovf_single", ovf, 0);
    check("t3_out_L0_kept", out_L0, 16'h1234);
    check("t3_count_L0_kept", count_L0, 4);
    in_valid = 1'b0;
    @(negedge clk);
    press(1, 4'h9);
    check("t3_out_L1", out_L1, 16'h0079);
    check("t3_in_ready", in_ready, 1);
    check("t3_ovf_quiet", ovf, 0);

    // 4: clear wins over same-buffer write; other buffer still written
    @(negedge clk);
    S = 1'b0; dig = 4'h5; in_valid = 1'b1; clr_L0 = 1'b1;
    @(negedge clk);
    clr_L0 = 1'b0;
    check("t4_out_L0", out_L0, 0);
    check("t4_count_L0", count_L0, 0);
    check("t4_full_L0", full_L0, 0);
    check("t4_ovf", ovf, 0);
    in_valid = 1'b0;
    @(negedge clk);
    press(0, 4'h3);
    check("t4_out_L0_refill", out_L0, 16'h0003);
    @(negedge clk);
    S = 1'b1; dig = 4'h5; in_valid = 1'b1; clr_L0 = 1'b1;
    @(negedge clk);
    clr_L0 = 1'b0;
    check("t4_L0_cleared", out_L0, 0);
    check("t4_out_L1", out_L1, 16'h0795);
    check("t4_count_L1", count_L1, 3);
    in_valid = 1'b0;
    @(negedge clk);

    // 5: both clear, then alternate S
    clear_both();
    check("t5_both_clr_L1", out_L1, 0);
    check("t5_both_clr_cnt1", count_L1, 0);
    for (int i = 1; i <= 8; i++) press(i[0] ? 1'b0 : 1'b1, 4'(i));
    check("t5_out_L0", out_L0, 16'h1357);
    check("t5_out_L1", out_L1, 16'h2468);
    check("t5_full_L0", full_L0, 1);
    check("t5_full_L1", full_L1, 1);

    // 6: reset mid-entry, key held across release
    clear_both();
    press(0, 4'h1); press(0, 4'h2);
    check("t6_pre_out_L0", out_L0, 16'h0012);
    @(negedge clk);
    rst_n = 1'b0; S = 1'b0; dig = 4'h6; in_valid = 1'b1;
    @(negedge clk);
    check("t6_rst_out_L0", out_L0, 0);
    check("t6_rst_count_L0", count_L0, 0);
    check("t6_rst_full_L0", full_L0, 0);
    check("t6_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rel_count_L0", count_L0, 1);
    check("t6_rel_out_L0", out_L0, 16'h0006);
    repeat (3) @(negedge clk);
    check("t6_held_once", count_L0, 1);
    in_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
